operand_tf_seq_lane: RTL and testbench
======================================

OPERAND_TF_SEQ_LANE -- requirements
Module: operand_tf_seq_lane

Interface
REQ-001 SHALL have parameter NUM_ELEM, default 4: elements per group sharing one micro scale; legal range 1..64.
REQ-002 SHALL have parameter ELEM_W_IN, default ELEM_WIDTH_IN from operand_tf_pkg: input element width.
REQ-003 SHALL have parameter SCALE_W, default SCALE_WIDTH from operand_tf_pkg: micro scale width.
REQ-004 SHALL have parameter ELEM_W_OUT, default ELEM_WIDTH_OUT from operand_tf_pkg: result element width.
REQ-005 SHALL have port clk, input, 1: the single clock; all flops rise-edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1: group offered.
REQ-008 SHALL have port in_ready, output, 1: group accepted when in_valid && in_ready at a clk edge.
REQ-009 SHALL have port in_elems, input, NUM_ELEM*ELEM_W_IN: element i at bits [i*ELEM_W_IN +: ELEM_W_IN].
REQ-010 SHALL have port in_scale, input, SCALE_W: shared unsigned micro scale.
REQ-011 SHALL have port in_bypass, input, 1: when 1, scaling is skipped for the group.
REQ-012 SHALL have port out_valid, output, 1: results group valid.
REQ-013 SHALL have port out_ready, input, 1: consumer accepts when out_valid && out_ready.
REQ-014 SHALL have port out_elems, output, NUM_ELEM*ELEM_W_OUT: result i at bits [i*ELEM_W_OUT +: ELEM_W_OUT].
REQ-015 SHALL have port busy, output, 1: high in state COMPUTE.

Function
REQ-016 SHALL implement the FSM IDLE -> COMPUTE -> DONE, encoded as a package enum.
REQ-017 On acceptance, SHALL capture in_elems, in_scale and in_bypass into input buffers, clear the index counter to 0, and enter COMPUTE.
REQ-018 In COMPUTE, SHALL process the element at the current index through one shared multiplier each cycle and write the result to result register [index] at the clock edge.
REQ-019 In COMPUTE, SHALL increment the index each cycle and move to DONE on the edge that writes index NUM_ELEM-1.
REQ-020 Latency SHALL be that out_valid rises exactly NUM_ELEM cycles after the acceptance edge.
REQ-021 Arithmetic, when in_bypass=0: result is the unsigned product elem*scale, saturated to 2^ELEM_W_OUT-1 when it exceeds ELEM_W_OUT bits.
REQ-022 Arithmetic, when in_bypass=1: result is the element, zero-extended to ELEM_W_OUT bits or saturated if wider.
REQ-023 out_valid SHALL equal (state==DONE); out_elems SHALL hold stable while out_valid && !out_ready.
REQ-024 On a DONE handshake, SHALL go to IDLE, or to COMPUTE if a new group is accepted on the same edge.
REQ-025 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready); it is low throughout COMPUTE.
REQ-026 in_valid and input data SHALL be ignored while in_ready is low; input buffers change only on acceptance.
REQ-027 When NUM_ELEM=1, COMPUTE SHALL last exactly one cycle and the index counter SHALL be 1 bit wide.
REQ-028 Result registers not yet rewritten during COMPUTE SHALL retain prior values; consumers use out_elems only while out_valid.

Reset
REQ-029 rst high SHALL immediately force state to IDLE, the index to 0, and all input buffers and result registers to 0, regardless of clk.
REQ-030 While rst is high, outputs SHALL be in_ready=0, out_valid=0, busy=0 and out_elems=0; in_ready rises the first cycle after rst falls.
REQ-031 rst asserted mid-COMPUTE or in DONE SHALL abort the group with no output produced.

Structure
REQ-032 operand_tf_pkg SHALL hold the ELEM_WIDTH_IN, SCALE_WIDTH and ELEM_WIDTH_OUT defaults and the FSM state typedef.
REQ-033 Scaling/saturation SHALL live in one parametrised combinational sub-module, operand_tf_sat_mul, instantiated once.

Verification
REQ-034 Defaults 8/8/16 with NUM_ELEM=4: elems {1,2,3,255}, scale 3, bypass 0 -> out_elems {3,6,9,765}, with out_valid exactly 4 cycles after acceptance.
REQ-035 ELEM_W_OUT=8: elem 200, scale 2 -> 255 (saturated); elem 100, scale 2 -> 200.
REQ-036 Bypass: elems {7,0,128,255}, scale 9, bypass 1 -> {7,0,128,255}.
REQ-037 Backpressure: hold out_ready=0 for 5 cycles -> out_elems stable and in_ready low; then out_ready=1 with in_valid=1 -> back-to-back acceptance with no IDLE cycle.
REQ-038 Reset mid-run: assert rst at COMPUTE index 2 -> out_valid=0 and out_elems=0 immediately; the next group completes correctly.
REQ-039 NUM_ELEM=1: elem 5, scale 4 -> 20 one cycle after acceptance; busy high for exactly 1 cycle.

Source files
------------

// File: rtl/operand_tf_pkg.sv
// Shared widths and FSM state type for the operand transform lane.
package operand_tf_pkg;

    localparam int unsigned ELEM_WIDTH_IN  = 8;
    localparam int unsigned SCALE_WIDTH    = 8;
    localparam int unsigned ELEM_WIDTH_OUT = 16;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

endpackage

// File: rtl/operand_tf_sat_mul.sv
// Unsigned element*scale (or element pass-through) saturated to the result width.
module operand_tf_sat_mul
    import operand_tf_pkg::*;
#(
    parameter int unsigned ELEM_W_IN  = ELEM_WIDTH_IN,
    parameter int unsigned SCALE_W    = SCALE_WIDTH,
    parameter int unsigned ELEM_W_OUT = ELEM_WIDTH_OUT
) (
    input  logic [ELEM_W_IN-1:0]  elem,
    input  logic [SCALE_W-1:0]    scale,
    input  logic                  bypass,
    output logic [ELEM_W_OUT-1:0] result
);

    localparam int unsigned PROD_W = ELEM_W_IN + SCALE_W;
    // Work width covers both the full product and the result, so one compare saturates either path.
    localparam int unsigned MW = (PROD_W > ELEM_W_OUT) ? PROD_W : ELEM_W_OUT;

    logic [MW-1:0] prod_w;
    logic [MW-1:0] sel_w;
    logic [MW-1:0] max_out;

    always_comb begin
        max_out                   = '0;
        max_out[ELEM_W_OUT-1:0]   = '1;
        prod_w                    = MW'(elem) * MW'(scale);
        sel_w                     = bypass ? MW'(elem) : prod_w;
        if (sel_w > max_out)
            result = '1;
        else
            result = sel_w[ELEM_W_OUT-1:0];
    end

endmodule

// File: rtl/operand_tf_seq_lane.sv
// Sequential lane: accepts a group of elements with one shared scale and
// scales them one per cycle through a single saturating multiplier.
module operand_tf_seq_lane
    import operand_tf_pkg::*;
#(
    parameter int unsigned NUM_ELEM   = 4,
    parameter int unsigned ELEM_W_IN  = ELEM_WIDTH_IN,
    parameter int unsigned SCALE_W    = SCALE_WIDTH,
    parameter int unsigned ELEM_W_OUT = ELEM_WIDTH_OUT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_ELEM*ELEM_W_IN-1:0]  in_elems,
    input  logic [SCALE_W-1:0]             in_scale,
    input  logic                           in_bypass,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_ELEM*ELEM_W_OUT-1:0] out_elems,
    output logic                           busy
);

    localparam int unsigned IDX_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;

    state_t                state;
    state_t                state_nxt;
    logic [IDX_W-1:0]      idx;
    logic [ELEM_W_IN-1:0]  elem_buf [NUM_ELEM];
    logic [SCALE_W-1:0]    scale_buf;
    logic                  bypass_buf;
    logic [ELEM_W_OUT-1:0] res [NUM_ELEM];
    logic [ELEM_W_IN-1:0]  cur_elem;
    logic [ELEM_W_OUT-1:0] mul_out;
    logic                  accept;
    logic                  last_idx;

    assign accept   = in_valid && in_ready;
    assign last_idx = (idx == IDX_W'(NUM_ELEM - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = COMPUTE;
            COMPUTE: if (last_idx) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = accept ? COMPUTE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Reset holds state at IDLE, so in_ready is gated by rst to stay low during reset.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    in_ready = !rst;
            COMPUTE: busy = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready && !rst;
            end
            default: ;
        endcase
    end

    always_comb begin
        cur_elem = '0;
        for (int unsigned i = 0; i < NUM_ELEM; i++)
            if (idx == IDX_W'(i))
                cur_elem = elem_buf[i];
    end

    operand_tf_sat_mul #(
        .ELEM_W_IN  (ELEM_W_IN),
        .SCALE_W    (SCALE_W),
        .ELEM_W_OUT (ELEM_W_OUT)
    ) u_sat_mul (
        .elem   (cur_elem),
        .scale  (scale_buf),
        .bypass (bypass_buf),
        .result (mul_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            scale_buf  <= '0;
            bypass_buf <= 1'b0;
            for (int unsigned i = 0; i < NUM_ELEM; i++) begin
                elem_buf[i] <= '0;
                res[i]      <= '0;
            end
        end else if (accept) begin
            idx        <= '0;
            scale_buf  <= in_scale;
            bypass_buf <= in_bypass;
            for (int unsigned i = 0; i < NUM_ELEM; i++)
                elem_buf[i] <= in_elems[i*ELEM_W_IN +: ELEM_W_IN];
        end else if (state == COMPUTE) begin
            idx <= idx + IDX_W'(1);
            for (int unsigned i = 0; i < NUM_ELEM; i++)
                if (idx == IDX_W'(i))
                    res[i] <= mul_out;
        end
    end

    always_comb begin
        out_elems = '0;
        for (int unsigned i = 0; i < NUM_ELEM; i++)
            out_elems[i*ELEM_W_OUT +: ELEM_W_OUT] = res[i];
    end

endmodule

// File: tb/tb_operand_tf_seq_lane.sv
// Directed bench for operand_tf_seq_lane: default, narrow-output and single-element configurations.
module tb_operand_tf_seq_lane;

    logic clk;
    logic rst;

    logic        d_in_valid, d_in_ready, d_in_bypass, d_out_valid, d_out_ready, d_busy;
    logic [31:0] d_in_elems;
    logic [7:0]  d_in_scale;
    logic [63:0] d_out_elems;

    logic        s_in_valid, s_in_ready, s_in_bypass, s_out_valid, s_out_ready, s_busy;
    logic [15:0] s_in_elems;
    logic [7:0]  s_in_scale;
    logic [15:0] s_out_elems;

    logic        o_in_valid, o_in_ready, o_in_bypass, o_out_valid, o_out_ready, o_busy;
    logic [7:0]  o_in_elems;
    logic [7:0]  o_in_scale;
    logic [15:0] o_out_elems;

    int pass_cnt  = 0;
    int total_cnt = 0;

    operand_tf_seq_lane u_dut (
        .clk(clk), .rst(rst),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_elems(d_in_elems),
        .in_scale(d_in_scale), .in_bypass(d_in_bypass),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_elems(d_out_elems),
        .busy(d_busy)
    );

    operand_tf_seq_lane #(.NUM_ELEM(2), .ELEM_W_OUT(8)) u_sat (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_elems(s_in_elems),
        .in_scale(s_in_scale), .in_bypass(s_in_bypass),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_elems(s_out_elems),
        .busy(s_busy)
    );

    operand_tf_seq_lane #(.NUM_ELEM(1)) u_one (
        .clk(clk), .rst(rst),
        .in_valid(o_in_valid), .in_ready(o_in_ready), .in_elems(o_in_elems),
        .in_scale(o_in_scale), .in_bypass(o_in_bypass),
        .out_valid(o_out_valid), .out_ready(o_out_ready), .out_elems(o_out_elems),
        .busy(o_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Caller guarantees d_in_ready; returns at the negedge after the acceptance edge.
    task automatic dut_send(input logic [31:0] e, input logic [7:0] s, input logic b);
        d_in_elems  = e;
        d_in_scale  = s;
        d_in_bypass = b;
        d_in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d_in_valid = 1'b0;
    endtask

    // Cycles from the acceptance edge until out_valid is seen; -1 if the budget expires.
    task automatic dut_wait_valid(output int lat);
        lat = -1;
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (d_out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        int          busy_cnt;
        logic [63:0] held;

        rst = 1'b1;
        d_in_valid = 1'b0; d_in_elems = '0; d_in_scale = '0; d_in_bypass = 1'b0; d_out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_elems = '0; s_in_scale = '0; s_in_bypass = 1'b0; s_out_ready = 1'b1;
        o_in_valid = 1'b0; o_in_elems = '0; o_in_scale = '0; o_in_bypass = 1'b0; o_out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(d_in_ready), 64'd0);
        check("rst_out_valid", 64'(d_out_valid), 64'd0);
        check("rst_busy", 64'(d_busy), 64'd0);
        check("rst_out_elems", d_out_elems, 64'd0);
        check("rst_sat_in_ready", 64'(s_in_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(d_in_ready), 64'd1);

        // Main product path: {1,2,3,255} * 3
        dut_send({8'd255, 8'd3, 8'd2, 8'd1}, 8'd3, 1'b0);
        check("mul_busy", 64'(d_busy), 64'd1);
        check("mul_in_ready_low", 64'(d_in_ready), 64'd0);
        dut_wait_valid(lat);
        check("mul_latency", 64'(lat), 64'd4);
        check("mul_result", d_out_elems, {16'd765, 16'd9, 16'd6, 16'd3});
        @(negedge clk);
        check("mul_back_idle", 64'(d_out_valid), 64'd0);

        // Bypass passes elements through despite a non-unity scale
        dut_send({8'd255, 8'd128, 8'd0, 8'd7}, 8'd9, 1'b1);
        dut_wait_valid(lat);
        check("byp_latency", 64'(lat), 64'd4);
        check("byp_result", d_out_elems, {16'd255, 16'd128, 16'd0, 16'd7});
        @(negedge clk);

        // Backpressure; the next group is offered during COMPUTE and must wait
        d_out_ready = 1'b0;
        dut_send({8'd40, 8'd30, 8'd20, 8'd10}, 8'd2, 1'b0);
        d_in_elems  = {8'd1, 8'd1, 8'd1, 8'd1};
        d_in_scale  = 8'd5;
        d_in_bypass = 1'b0;
        d_in_valid  = 1'b1;
        dut_wait_valid(lat);
        check("bp_latency", 64'(lat), 64'd4);
        check("bp_result", d_out_elems, {16'd80, 16'd60, 16'd40, 16'd20});
        held = d_out_elems;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold_valid", 64'(d_out_valid), 64'd1);
            check("bp_hold_in_ready", 64'(d_in_ready), 64'd0);
            check("bp_hold_elems", d_out_elems, held);
        end
        d_out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 64'(d_in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        d_in_valid = 1'b0;
        check("b2b_busy", 64'(d_busy), 64'd1);
        check("b2b_out_valid", 64'(d_out_valid), 64'd0);
        dut_wait_valid(lat);
        check("b2b_latency", 64'(lat), 64'd4);
        check("b2b_result", d_out_elems, {16'd5, 16'd5, 16'd5, 16'd5});

        // Reset while COMPUTE is at index 2
        dut_send({8'd4, 8'd3, 8'd2, 8'd1}, 8'd10, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(d_out_valid), 64'd0);
        check("midrst_out_elems", d_out_elems, 64'd0);
        check("midrst_busy", 64'(d_busy), 64'd0);
        check("midrst_in_ready", 64'(d_in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_recover_ready", 64'(d_in_ready), 64'd1);
        check("midrst_no_output", 64'(d_out_valid), 64'd0);
        dut_send({8'd6, 8'd7, 8'd8, 8'd9}, 8'd2, 1'b0);
        dut_wait_valid(lat);
        check("midrst_latency", 64'(lat), 64'd4);
        check("midrst_result", d_out_elems, {16'd12, 16'd14, 16'd16, 16'd18});

        // Narrow output: 200*2 saturates to 255, 100*2 = 200
        s_in_elems = {8'd100, 8'd200};
        s_in_scale = 8'd2;
        s_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_in_valid = 1'b0;
        check("sat_busy", 64'(s_busy), 64'd1);
        lat = -1;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (s_out_valid) begin
                lat = n;
                break;
            end
        end
        check("sat_latency", 64'(lat), 64'd2);
        check("sat_result", 64'(s_out_elems), {48'd0, 8'd200, 8'd255});

        // Single element: 5*4 one cycle after acceptance, busy for one cycle
        o_in_elems = 8'd5;
        o_in_scale = 8'd4;
        o_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        o_in_valid = 1'b0;
        lat = -1;
        busy_cnt = 0;
        for (int n = 0; n < 6; n++) begin
            if (o_busy) busy_cnt++;
            if (o_out_valid && lat < 0) begin
                lat = n;
                check("one_result", 64'(o_out_elems), 64'd20);
            end
            @(posedge clk);
            @(negedge clk);
        end
        check("one_latency", 64'(lat), 64'd1);
        check("one_busy_cycles", 64'(busy_cnt), 64'd1);
        check("one_in_ready_idle", 64'(o_in_ready), 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
